alu_seq: RTL and testbench

//  Multi-byte operation sequencer for the 8-bit combinational ALU (op[3:0], mode, active-low carry-in).

---
 rtl/alu_seq.sv | 124 ++++++++++++
 tb/tb_alu_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-byte op sequencer driving an 8-bit ALU LSB-first with carry chaining; optional ALU_SEQ_FLAGS_EN adds zero/neg flags.
// Latency: rsp_valid rises NBYTES cycles after the accept edge; one op per NBYTES+2 cycles.
// Backpressure: req_ready only in IDLE; rsp_ready low holds DONE with outputs frozen.
module alu_seq #(
  parameter int NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [8*NBYTES-1:0]   req_a,
  input  logic [8*NBYTES-1:0]   req_b,
  input  logic [3:0]            req_op,
  input  logic                  req_mode,
  input  logic                  req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_result,
  output logic                  rsp_cout,
`ifdef ALU_SEQ_FLAGS_EN
  output logic                  rsp_zero,
  output logic                  rsp_neg,
`endif
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic                  alu_cf_in,
  output logic [3:0]            alu_op,
  output logic                  alu_mode,
  input  logic [7:0]            alu_out,
  input  logic                  alu_cf_out
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state, state_nxt;
  logic [IW-1:0]            idx;
  logic [NBYTES-1:0][7:0]   a_q, b_q, result, result_nxt;
  logic [3:0]               op_q;
  logic                     mode_q, cin_q, carry_q;
  logic                     accept, last;

  assign accept     = (state == IDLE) && req_valid;
  assign last       = (idx == IW'(NBYTES - 1));
  assign rsp_result = result;

  always_comb begin
    result_nxt      = result;
    result_nxt[idx] = alu_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == DONE);
    alu_a     = 8'h00;
    alu_b     = 8'h00;
    alu_op    = 4'h0;
    alu_mode  = 1'b0;
    alu_cf_in = 1'b1;
    if (state == RUN) begin
      alu_a     = a_q[idx];
      alu_b     = b_q[idx];
      alu_op    = op_q;
      alu_mode  = mode_q;
      // Active-low carry-in: re-invert the previous byte's carry/borrow out.
      alu_cf_in = (idx == '0) ? cin_q : ~carry_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 4'h0;
      mode_q   <= 1'b0;
      cin_q    <= 1'b1;
      carry_q  <= 1'b0;
      result   <= '0;
      rsp_cout <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      rsp_zero <= 1'b0;
      rsp_neg  <= 1'b0;
`endif
    end else if (accept) begin
      idx    <= '0;
      a_q    <= req_a;
      b_q    <= req_b;
      op_q   <= req_op;
      mode_q <= req_mode;
      cin_q  <= req_cin;
    end else if (state == RUN) begin
      result  <= result_nxt;
      carry_q <= alu_cf_out;
      if (last) begin
        idx      <= '0;
        rsp_cout <= mode_q ? 1'b0 : alu_cf_out;
`ifdef ALU_SEQ_FLAGS_EN
        rsp_zero <= (result_nxt == '0);
        rsp_neg  <= result_nxt[NBYTES-1][7];
`endif
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (NBYTES=2) with a small behavioural 8-bit ALU model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_a = '0, req_b = '0;
  logic [3:0]  req_op = '0;
  logic        req_mode = 1'b0, req_cin = 1'b1;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic        rsp_cout;
`ifdef ALU_SEQ_FLAGS_EN
  logic        rsp_zero, rsp_neg;
`endif
  logic [7:0]  alu_a, alu_b, alu_out;
  logic        alu_cf_in, alu_mode, alu_cf_out;
  logic [3:0]  alu_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.NBYTES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_mode(req_mode), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_cout(rsp_cout),
`ifdef ALU_SEQ_FLAGS_EN
    .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_cf_in(alu_cf_in), .alu_op(alu_op), .alu_mode(alu_mode),
    .alu_out(alu_out), .alu_cf_out(alu_cf_out)
  );

  // ALU model: cf_in active-low; add gives carry, sub gives borrow on cf_out.
  always_comb begin
    logic [8:0] t;
    t = 9'h000;
    if (alu_mode) begin
      if (alu_op == 4'b0110) t = {1'b0, alu_a ^ alu_b};
      else                   t = {1'b0, alu_a & alu_b};
    end else begin
      case (alu_op)
        4'b1001: t = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, ~alu_cf_in};
        4'b0110: t = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, ~alu_cf_in};
        default: t = {1'b0, alu_a};
      endcase
    end
    alu_out    = t[7:0];
    alu_cf_out = t[8];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op and stop at the first DONE cycle without handshaking.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] op, input logic mode, input logic cin,
                        input logic [15:0] er, input logic ec, input logic ecf1);
    @(negedge clk);
    chk({tag, ".req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op; req_mode = mode; req_cin = cin;
    @(negedge clk);
    req_valid = 1'b0; req_a = ~a; req_b = ~b; req_cin = ~cin; req_op = ~op;
    chk({tag, ".busy"}, req_ready, 0);
    chk({tag, ".alu_a0"}, alu_a, a[7:0]);
    chk({tag, ".alu_b0"}, alu_b, b[7:0]);
    chk({tag, ".cf_in0"}, alu_cf_in, cin);
    chk({tag, ".alu_op"}, alu_op, op);
    chk({tag, ".alu_mode"}, alu_mode, mode);
    @(negedge clk);
    chk({tag, ".alu_a1"}, alu_a, a[15:8]);
    chk({tag, ".cf_in1"}, alu_cf_in, ecf1);
    chk({tag, ".vld_early"}, rsp_valid, 0);
    @(negedge clk);
    chk({tag, ".rsp_valid"}, rsp_valid, 1);
    chk({tag, ".result"}, rsp_result, er);
    chk({tag, ".cout"}, rsp_cout, ec);
    chk({tag, ".bus_idle"}, {alu_a, alu_b, alu_op, alu_mode, alu_cf_in}, 22'h1);
`ifdef ALU_SEQ_FLAGS_EN
    chk({tag, ".zero"}, rsp_zero, (er == 16'h0));
    chk({tag, ".neg"}, rsp_neg, er[15]);
`endif
  endtask

  task automatic take_rsp(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".vld_drop"}, rsp_valid, 0);
    chk({tag, ".ready_back"}, req_ready, 1);
  endtask

  initial begin
    #12;
    chk("rst.valid", rsp_valid, 0);
    chk("rst.result", rsp_result, 16'h0000);
    chk("rst.cout", rsp_cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.req_ready", req_ready, 1);
    chk("rst.cf_in", alu_cf_in, 1);
    chk("rst.alu_a", alu_a, 8'h00);

    run_op("add_ff", 16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
    take_rsp("add_ff");
    run_op("add_wrap", 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    take_rsp("add_wrap");
    run_op("sub", 16'h0100, 16'h0001, 4'b0110, 1'b0, 1'b1, 16'h00FF, 1'b0, 1'b0);
    take_rsp("sub");
    run_op("xor", 16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 16'h0FF0, 1'b0, 1'b1);
    take_rsp("xor");

    // Back-pressure: hold DONE for 5 cycles while a competing request is offered.
    run_op("bp", 16'h8000, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b1);
    req_valid = 1'b1; req_a = 16'h1111; req_b = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp.hold_vld%0d", i), rsp_valid, 1);
      chk($sformatf("bp.hold_res%0d", i), rsp_result, 16'h8001);
      chk($sformatf("bp.hold_rdy%0d", i), req_ready, 0);
    end
    req_valid = 1'b0;
    take_rsp("bp");

    // Reset in RUN at idx=1, then a clean op.
    @(negedge clk);
    req_valid = 1'b1; req_a = 16'hAAAA; req_b = 16'h5555; req_op = 4'b1001; req_mode = 1'b0; req_cin = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort.in_run", alu_a, 8'hAA);
    rst_n = 1'b0;
    #1;
    chk("abort.valid", rsp_valid, 0);
    chk("abort.result", rsp_result, 16'h0000);
    chk("abort.cf_in", alu_cf_in, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort.req_ready", req_ready, 1);
    chk("abort.no_rsp", rsp_valid, 0);
    run_op("post", 16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b1, 16'h2345, 1'b0, 1'b1);
    take_rsp("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
